cdb_arbiter: RTL and testbench

- Shares the single CDB broadcast into the ROB (rob_tag + value, tag 0 = no broadcast) among NUM_FU functional units.
- Each FU has a one-entry holding slot. A round-robin scheduler picks one valid slot per cycle and drives a registered CDB packet to the ROB, RS and map table.
- Backpressure goes to each FU through a per-FU ready signal.
- squash empties every slot on a branch mispredict or flush.

---
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast among NUM_FU one-entry FU slots.
// Optional saturating contention counter enabled with `define CDB_ARB_STATS_EN.
module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned XLEN   = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU*XLEN-1:0]    fu_value,
    output logic [NUM_FU-1:0]         fu_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [XLEN-1:0]           cdb_value,
    output logic [$clog2(NUM_FU)-1:0] cdb_fu_idx
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [15:0]               conflict_cycles
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_FU);

    logic [NUM_FU-1:0] slot_valid_q, slot_valid_d;
    logic [TAG_W-1:0]  slot_tag_q   [NUM_FU];
    logic [XLEN-1:0]   slot_value_q [NUM_FU];
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] accept;
    logic              grant_any;
    logic [IdxW-1:0]   winner;
    logic [IdxW-1:0]   scan_idx;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [XLEN-1:0]   cdb_value_q;
    logic [IdxW-1:0]   cdb_fu_idx_q;

    // First valid slot at or after rr_ptr (wrapping) wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            scan_idx = IdxW'((32'(rr_ptr_q) + k) % NUM_FU);
            if (!grant_any && slot_valid_q[scan_idx]) begin
                grant_any = 1'b1;
                winner    = scan_idx;
            end
        end
        if (grant_any) begin
            grant[winner] = 1'b1;
        end
    end

    // A granted slot drains this cycle, so it can take a new result at the same edge.
    assign fu_ready = ~slot_valid_q | grant;

    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            accept[i] = fu_valid[i] && fu_ready[i] && (fu_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot_valid_d[i] = 1'b1;
            end else if (grant[i]) begin
                slot_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = IdxW'((32'(winner) + 1) % NUM_FU);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid_q <= '0;
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_value_q  <= '0;
            cdb_fu_idx_q <= '0;
        end else if (squash) begin
            slot_valid_q <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_value_q  <= '0;
            cdb_fu_idx_q <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= grant_any;
            cdb_tag_q    <= grant_any ? slot_tag_q[winner] : '0;
            cdb_value_q  <= grant_any ? slot_value_q[winner] : '0;
            cdb_fu_idx_q <= grant_any ? winner : '0;
        end
    end

    // Payload needs no reset: it is only observed while its valid bit is set.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot_tag_q[i]   <= fu_tag[i*TAG_W +: TAG_W];
                slot_value_q[i] <= fu_value[i*XLEN +: XLEN];
            end
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_value  = cdb_value_q;
    assign cdb_fu_idx = cdb_fu_idx_q;

`ifdef CDB_ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (($countones(slot_valid_q) >= 2) && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cycles = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a slot-level reference model queues expected broadcasts,
// and an independent negedge monitor checks every CDB cycle against that queue.
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 4;
    localparam int XLEN   = 32;
    localparam int IDX_W  = $clog2(NUM_FU);

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    squash;
    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]  fu_value;
    logic [NUM_FU-1:0]       fu_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_value;
    logic [IDX_W-1:0]        cdb_fu_idx;
`ifdef CDB_ARB_STATS_EN
    logic [15:0]             conflict_cycles;
`endif

    cdb_arbiter #(
        .NUM_FU(NUM_FU),
        .TAG_W (TAG_W),
        .XLEN  (XLEN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_fu_idx(cdb_fu_idx)
`ifdef CDB_ARB_STATS_EN
        ,
        .conflict_cycles(conflict_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        int               idx;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    // Reference model: one entry per FU plus a round-robin start position.
    bit               m_v [NUM_FU];
    logic [TAG_W-1:0] m_t [NUM_FU];
    logic [XLEN-1:0]  m_d [NUM_FU];
    int               m_rr   = 0;
    int               m_conf = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: CDB outputs are registered, so sample them mid-cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            if (cdb_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_bcast: got tag %0h idx %0d, expected no broadcast (cycle %0d)",
                             cdb_tag, cdb_fu_idx, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || cdb_tag != e.tag || cdb_value != e.value ||
                        int'(cdb_fu_idx) != e.idx) begin
                        n_fail++;
                        $display("FAIL bcast: got cyc %0d tag %0h val %0h idx %0d, expected cyc %0d tag %0h val %0h idx %0d",
                                 cyc, cdb_tag, cdb_value, cdb_fu_idx, e.cyc, e.tag, e.value, e.idx);
                    end
                end
            end else begin
                n_tests++;
                if (cdb_tag != '0 || cdb_value != '0 || cdb_fu_idx != '0) begin
                    n_fail++;
                    $display("FAIL idle_zero: got tag %0h val %0h idx %0d, expected all 0 (cycle %0d)",
                             cdb_tag, cdb_value, cdb_fu_idx, cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    n_fail++;
                    $display("FAIL missing_bcast: got no broadcast, expected tag %0h idx %0d (cycle %0d)",
                             exp_q[0].tag, exp_q[0].idx, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Apply one cycle of stimulus, check fu_ready, and advance the model across the next edge.
    task automatic drive_cycle(input logic [NUM_FU-1:0] v, input logic [NUM_FU*TAG_W-1:0] t,
                               input logic [NUM_FU*XLEN-1:0] d, input logic sq, input logic rst,
                               output logic [NUM_FU-1:0] rdy);
        int win;
        int nvalid;
        exp_t e;
        fu_valid = v;
        fu_tag   = t;
        fu_value = d;
        squash   = sq;
        reset    = rst;
        @(negedge clock);
        win    = -1;
        nvalid = 0;
        for (int off = 0; off < NUM_FU; off++) begin
            int i;
            i = (m_rr + off) % NUM_FU;
            if (win < 0 && m_v[i]) win = i;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            rdy[i] = !m_v[i] || (i == win);
            if (m_v[i]) nvalid++;
        end
        check("fu_ready", longint'(fu_ready), longint'(rdy));
`ifdef CDB_ARB_STATS_EN
        check("conflict_cycles", longint'(conflict_cycles), longint'(m_conf));
`endif
        if (rst) m_conf = 0;
        else if (nvalid >= 2 && m_conf < 65535) m_conf++;
        if (rst || sq) begin
            for (int i = 0; i < NUM_FU; i++) m_v[i] = 1'b0;
            if (rst) m_rr = 0;
        end else begin
            if (win >= 0) begin
                e.tag   = m_t[win];
                e.value = m_d[win];
                e.idx   = win;
                e.cyc   = cyc + 1;
                exp_q.push_back(e);
                m_v[win] = 1'b0;
                m_rr     = (win + 1) % NUM_FU;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (v[i] && rdy[i] && t[i*TAG_W +: TAG_W] != '0) begin
                    m_v[i] = 1'b1;
                    m_t[i] = t[i*TAG_W +: TAG_W];
                    m_d[i] = d[i*XLEN +: XLEN];
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        logic [NUM_FU-1:0] r;
        for (int k = 0; k < n; k++) drive_cycle('0, '0, '0, 1'b0, 1'b0, r);
    endtask

    initial begin
        logic [NUM_FU-1:0]       v;
        logic [NUM_FU-1:0]       rdy;
        logic [NUM_FU-1:0]       hold;
        logic [NUM_FU*TAG_W-1:0] t;
        logic [NUM_FU*XLEN-1:0]  d;
        logic                    sq;
        logic                    rst;
        logic [TAG_W-1:0]        alt [NUM_FU];

        reset    = 1'b1;
        squash   = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;
        for (int i = 0; i < NUM_FU; i++) m_v[i] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_cdb_valid", longint'(cdb_valid), 0);
        check("rst_cdb_tag", longint'(cdb_tag), 0);
        check("rst_cdb_value", longint'(cdb_value), 0);
        check("rst_cdb_fu_idx", longint'(cdb_fu_idx), 0);
        check("rst_fu_ready", longint'(fu_ready), longint'({NUM_FU{1'b1}}));
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        // Single result from FU2.
        t = '0; d = '0;
        t[2*TAG_W +: TAG_W] = 4'd5;
        d[2*XLEN +: XLEN]   = 32'hDEAD;
        drive_cycle(4'b0100, t, d, 1'b0, 1'b0, rdy);
        idle(4);

        // Four-way contention from rr_ptr = 0.
        drive_cycle('0, '0, '0, 1'b0, 1'b1, rdy);
        for (int i = 0; i < NUM_FU; i++) begin
            t[i*TAG_W +: TAG_W] = TAG_W'(i + 1);
            d[i*XLEN +: XLEN]   = 32'h1000 + i;
        end
        drive_cycle('1, t, d, 1'b0, 1'b0, rdy);
        idle(6);

        // FU0 and FU3 stream results; each FU holds its request while not ready.
        hold = '0;
        v    = 4'b1001;
        t    = '0;
        d    = '0;
        for (int i = 0; i < NUM_FU; i++) alt[i] = 4'd7;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (v[i] && !hold[i]) begin
                    alt[i] = (alt[i] == 4'd6) ? 4'd7 : 4'd6;
                    t[i*TAG_W +: TAG_W] = alt[i];
                    d[i*XLEN +: XLEN]   = $urandom;
                end
            end
            drive_cycle(v, t, d, 1'b0, 1'b0, rdy);
            hold = v & ~rdy;
        end
        idle(4);

        // Tag 0 requests are dropped.
        t = '0;
        d = '0;
        d[1*XLEN +: XLEN] = 32'hBAD0;
        for (int n = 0; n < 3; n++) drive_cycle(4'b0010, t, d, 1'b0, 1'b0, rdy);
        idle(3);

        // Squash with three held slots, then a fresh tag 8 from FU1.
        t = '0;
        t[0*TAG_W +: TAG_W] = 4'd9;
        t[1*TAG_W +: TAG_W] = 4'd10;
        t[2*TAG_W +: TAG_W] = 4'd11;
        drive_cycle(4'b0111, t, d, 1'b0, 1'b0, rdy);
        drive_cycle('0, '0, '0, 1'b1, 1'b0, rdy);
        idle(2);
        t = '0;
        t[1*TAG_W +: TAG_W] = 4'd8;
        d[1*XLEN +: XLEN]   = 32'h0000_0808;
        drive_cycle(4'b0010, t, d, 1'b0, 1'b0, rdy);
        idle(4);

        // Randomized traffic with occasional squash and reset.
        hold = '0;
        v    = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!hold[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    t[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
                    d[i*XLEN +: XLEN]   = $urandom;
                end
            end
            sq  = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 199) == 0);
            drive_cycle(v, t, d, sq, rst, rdy);
            hold = (sq || rst) ? '0 : (v & ~rdy);
        end
        idle(6);

        check("queue_drained", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
